uart_tx_serializer: RTL and testbench

//  Consumes the SoC's byte-wide UART transmit requests (tx_send strobe + tx_data) and drives the serial uart_tx pin.

---
 rtl/uart_tx_serializer_pkg.sv | 29 ++
 rtl/uart_tx_serializer_if.sv | 29 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_serializer.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Latency: n/a. This package holds only types, constants and elaboration-time helpers.
// Backpressure: n/a.
package uart_tx_serializer_pkg;

    typedef logic [7:0] byte_t;

    // Transmit FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Clock cycles per serial bit; clk_mhz==0 selects one clock per bit for fast simulation
    function automatic int calc_clks_per_bit(input int clk_mhz, input int baud);
        longint hz;
        if (clk_mhz == 0) begin
            return 1;
        end
        hz = longint'(clk_mhz) * 64'sd1000000;
        return int'(hz / longint'(baud));
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// SoC-facing request/status bundle of the UART transmitter.
// Latency: n/a. This file declares wires only.
// Backpressure: the master may push only while tx_ready is high. A push seen while the block is full is dropped and reported on tx_ovf.
interface uart_tx_serializer_if;
    import uart_tx_serializer_pkg::*;

    logic  tx_send;
    byte_t tx_data;
    logic  tx_ready;
    logic  tx_busy;
    logic  tx_ovf;

    modport master (
        output tx_send,
        output tx_data,
        input  tx_ready,
        input  tx_busy,
        input  tx_ovf
    );

    modport slave (
        input  tx_send,
        input  tx_data,
        output tx_ready,
        output tx_busy,
        output tx_ovf
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with power-of-two depth. Pointers are one bit wider than the address.
// Latency: a pushed word becomes visible on dout the cycle after the push edge. dout is valid while !empty.
// Backpressure: a push while full is ignored and a pop while empty is ignored. Simultaneous push and pop keeps the count unchanged.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Read and write pointers wrap naturally through the extra MSB
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array. It is not reset because the occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an 8N1 serializer that drives the uart_tx pad from a register.
// Latency: a byte pushed at edge N into an idle, empty block puts its start bit on the line at edge N+1. A frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: tx_ready=!full, with no look-ahead at a same-cycle pop. A send while full is dropped and sets sticky tx_ovf.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    uart_tx_serializer_if.slave  bus,
    output logic                 uart_tx
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_MHZ, BAUD);
    localparam int BW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_BIT = 3'(UART_STOP_BITS - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_nxt;
    byte_t         r_sh;
    byte_t         w_sh_nxt;
    logic [2:0]    r_bit_cnt;
    logic [2:0]    w_bit_cnt_nxt;
    logic [BW-1:0] r_baud_cnt;
    logic [BW-1:0] w_baud_cnt_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_busy;
    logic          r_ovf;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_bit_end;
    byte_t         w_dout;

    assign w_ready   = !w_full;
    assign w_push    = bus.tx_send && w_ready;
    assign w_bit_end = (r_baud_cnt == '0);

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (bus.tx_data),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty)
    );

    // FSM, shift register, baud counter and the registered line driver
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sh       <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_sh       <= w_sh_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Next-state logic. The line value is computed for the state being entered so uart_tx never glitches.
    always_comb begin
        w_state_nxt    = r_state;
        w_sh_nxt       = r_sh;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_cnt_nxt = r_baud_cnt;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_sh_nxt       = w_dout;
                    w_bit_cnt_nxt  = '0;
                    w_baud_cnt_nxt = BAUD_RELOAD;
                    w_state_nxt    = ST_START;
                    w_tx_nxt       = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = BAUD_RELOAD;
                    w_state_nxt    = ST_DATA;
                    w_tx_nxt       = r_sh[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - BW'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = BAUD_RELOAD;
                    w_sh_nxt       = r_sh >> 1;
                    if (r_bit_cnt == LAST_DATA_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_STOP;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_tx_nxt      = r_sh[1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - BW'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt != LAST_STOP_BIT) begin
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                        w_baud_cnt_nxt = BAUD_RELOAD;
                        w_tx_nxt       = 1'b1;
                    end else if (!w_empty) begin
                        // Back-to-back frames: the next start bit follows the stop bit with no idle gap
                        w_pop          = 1'b1;
                        w_sh_nxt       = w_dout;
                        w_bit_cnt_nxt  = '0;
                        w_baud_cnt_nxt = BAUD_RELOAD;
                        w_state_nxt    = ST_START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt - BW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Status flags: busy is registered from the current occupancy and state, and overflow is sticky until reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_busy <= !w_empty || (r_state != ST_IDLE);
            if (bus.tx_send && !w_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.tx_ready = w_ready;
    assign bus.tx_busy  = r_busy;
    assign bus.tx_ovf   = r_ovf;
    assign uart_tx      = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: frame-level model plus directed scenarios for the UART transmitter.
module tb_uart_tx_serializer;
    import uart_tx_serializer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CPB0  = 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic uart_tx0;
    logic uart_tx1;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    uart_tx_serializer_if if0();
    uart_tx_serializer_if if1();

    uart_tx_serializer #(.CLK_MHZ(0), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .resetn(resetn), .bus(if0), .uart_tx(uart_tx0));

    uart_tx_serializer #(.CLK_MHZ(12), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .resetn(resetn), .bus(if1), .uart_tx(uart_tx1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model of dut0 (one clock per bit) ----------------
    byte_t m_q[$];
    int    m_pos   = -1;   // cycle index inside the current frame, -1 when no frame
    byte_t m_byte  = '0;
    logic  m_tx    = 1'b1;
    logic  m_ready = 1'b1;
    logic  m_busy  = 1'b0;
    logic  m_ovf   = 1'b0;

    function automatic logic line_bit(input int pos, input byte_t b);
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CPB0;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge resetn) begin : mdl
        int sz;
        bit in_frame;
        bit acc;
        if (!resetn) begin
            m_q.delete();
            m_pos = -1; m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_ovf = 1'b0;
        end else begin
            sz       = m_q.size();
            in_frame = (m_pos >= 0);
            acc      = if0.tx_send && (sz < DEPTH);
            if (if0.tx_send && !(sz < DEPTH)) m_ovf = 1'b1;
            m_busy = (sz != 0) || in_frame;
            if ((!in_frame || m_pos == 10*CPB0-1) && sz != 0) begin
                m_byte = m_q.pop_front();
                m_pos  = 0;
            end else if (in_frame) begin
                m_pos = (m_pos == 10*CPB0-1) ? -1 : m_pos + 1;
            end
            if (acc) m_q.push_back(if0.tx_data);
            m_ready = (m_q.size() < DEPTH);
            m_tx    = line_bit(m_pos, m_byte);
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("model_uart_tx", uart_tx0, m_tx);
        chk("model_tx_ready", if0.tx_ready, m_ready);
        chk("model_tx_busy", if0.tx_busy, m_busy);
        chk("model_tx_ovf", if0.tx_ovf, m_ovf);
    end

    // ---------------- line decoder for dut0 ----------------
    byte_t dec_q[$];
    int    d_start[$];
    int    d_pos = -1;
    byte_t d_sh  = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            d_pos = -1;
        end else if (d_pos < 0) begin
            if (uart_tx0 === 1'b0) begin
                d_pos = 0;
                d_start.push_back(cyc);
            end
        end else begin
            d_pos++;
            if (d_pos <= 8) begin
                d_sh[d_pos-1] = uart_tx0;
            end else begin
                chk("stop_bit", uart_tx0, 1'b1);
                dec_q.push_back(d_sh);
                d_pos = -1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_byte(input byte_t d);
        if0.tx_send = 1'b1;
        if0.tx_data = d;
        @(posedge clk); #1;
        if0.tx_send = 1'b0;
        if0.tx_data = ~d;   // later changes must not affect the queued byte
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        #1;
        while (if0.tx_busy !== 1'b0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, if0.tx_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int t1_exp[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        bit t3_rdy[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
        byte_t t2_exp[3] = '{8'h48, 8'h69, 8'h0A};
        byte_t push_log[$];
        int n, run, total, sent, guard;
        logic lvl;

        if0.tx_send = 1'b0; if0.tx_data = '0;
        if1.tx_send = 1'b0; if1.tx_data = '0;

        // Reset state
        #12;
        chk("rst_uart_tx", uart_tx0, 1'b1);
        chk("rst_tx_ready", if0.tx_ready, 1'b1);
        chk("rst_tx_busy", if0.tx_busy, 1'b0);
        chk("rst_tx_ovf", if0.tx_ovf, 1'b0);
        #11 resetn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 1: single byte 0x41
        push_byte(8'h41);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t1_bit%0d", i), uart_tx0, t1_exp[i]);
        end
        @(posedge clk); #1;
        chk("t1_busy_last_stop", if0.tx_busy, 1'b1);
        @(posedge clk); #1;
        chk("t1_busy_after_stop", if0.tx_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // 2: burst of three bytes on consecutive cycles
        dec_q.delete(); d_start.delete();
        if0.tx_send = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if0.tx_data = t2_exp[i];
            @(posedge clk); #1;
        end
        if0.tx_send = 1'b0;
        wait_idle("t2_idle_timeout");
        chk("t2_count", dec_q.size(), 3);
        for (int i = 0; i < 3 && i < dec_q.size(); i++)
            chk($sformatf("t2_byte%0d", i), dec_q[i], t2_exp[i]);
        chk("t2_count_starts", d_start.size(), 3);
        for (int i = 1; i < 3 && i < d_start.size(); i++)
            chk($sformatf("t2_gap%0d", i), d_start[i] - d_start[i-1], 10);

        // 4: real baud divisor on dut1, 0x55 -> every bit alternates
        if1.tx_send = 1'b1; if1.tx_data = 8'h55;
        @(posedge clk); #1;
        if1.tx_send = 1'b0;
        n = 0;
        while (uart_tx1 !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("t4_start_seen", uart_tx1, 1'b0);
        total = 0; lvl = 1'b0;
        for (int s = 0; s < 9; s++) begin
            run = 0;
            while (uart_tx1 === lvl && run < 2000) begin @(posedge clk); #1; run++; end
            total += run;
            chk($sformatf("t4_seg%0d_len", s), run, 104);
            lvl = ~lvl;
        end
        n = 0;
        while (if1.tx_busy !== 1'b0 && n < 3000) begin
            chk("t4_stop_high", uart_tx1, 1'b1);
            @(posedge clk); #1; n++;
        end
        // The 1040-cycle frame, plus one cycle because tx_busy is registered
        chk("t4_frame_plus_busy_lag", total + n, 1041);

        // 3: overflow with tx_send held for 12 cycles
        dec_q.delete();
        if0.tx_send = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if0.tx_data = byte_t'(k);
            @(posedge clk); #1;
            chk($sformatf("t3_ready_after%0d", k), if0.tx_ready, t3_rdy[k]);
        end
        if0.tx_send = 1'b0;
        chk("t3_ovf", if0.tx_ovf, 1'b1);
        wait_idle("t3_idle_timeout");
        chk("t3_count", dec_q.size(), 9);
        for (int i = 0; i < 9 && i < dec_q.size(); i++)
            chk($sformatf("t3_byte%0d", i), dec_q[i], i);
        chk("t3_ovf_sticky", if0.tx_ovf, 1'b1);

        // 5a: reset during the data bits of the first frame, 0xFF then 0x00 queued
        dec_q.delete();
        push_byte(8'hFF);
        push_byte(8'h00);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("t5a_line_high_async", uart_tx0, 1'b1);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("t5a_ready", if0.tx_ready, 1'b1);
        chk("t5a_busy", if0.tx_busy, 1'b0);
        chk("t5a_ovf", if0.tx_ovf, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("t5a_no_frame", dec_q.size(), 0);

        // 5b: reset while the line is low in the data bits of 0x00
        push_byte(8'h00);
        @(posedge clk); @(posedge clk); #3;
        chk("t5b_line_low_before", uart_tx0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("t5b_line_high_async", uart_tx0, 1'b1);
        @(posedge clk); #3;
        resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t5b_no_frame", dec_q.size(), 0);
        chk("t5b_busy", if0.tx_busy, 1'b0);

        // 6: 1000 random bytes, pushed at random while kept below full
        dec_q.delete();
        push_log.delete();
        sent = 0; guard = 0;
        while (sent < 1000 && guard < 40000) begin
            if (m_q.size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
                byte_t d;
                d = byte_t'($urandom_range(0, 255));
                if0.tx_send = 1'b1;
                if0.tx_data = d;
                push_log.push_back(d);
                sent++;
            end else begin
                if0.tx_send = 1'b0;
                if0.tx_data = byte_t'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            guard++;
        end
        if0.tx_send = 1'b0;
        chk("t6_all_sent", sent, 1000);
        wait_idle("t6_idle_timeout");
        chk("t6_count", dec_q.size(), push_log.size());
        for (int i = 0; i < push_log.size() && i < dec_q.size(); i++)
            chk($sformatf("t6_byte%0d", i), dec_q[i], push_log[i]);
        chk("t6_ovf", if0.tx_ovf, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
